instr_encoder_loader: RTL and testbench

- Writer-side counterpart to the core's main opcode decoder. Accepts abstract instruction requests (kind + fields) over a valid/ready handshake and encodes them into 32-bit RV32I words.
- Streams the words sequentially into instruction memory through a simple write port. Used by the boot/test harness to build programs in-system.
- Emits only opcodes the decoder supports: jal, jalr, OP-IMM, OP, sb, bne, lui, lbu. Also expands the pseudo-op LI into lui+addi when needed.

---
 rtl/enc_pkg.sv | 52 +++++
 rtl/instr_format_enc.sv | 36 +++
 rtl/instr_encoder_loader.sv | 135 +++++++++++++
 tb/tb_instr_encoder_loader.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared types and RV32I encoding constants for the instruction encoder/loader.
package enc_pkg;

  typedef enum logic [3:0] {
    JAL   = 4'd0,
    JALR  = 4'd1,
    OPIMM = 4'd2,
    OP    = 4'd3,
    SB    = 4'd4,
    BNE   = 4'd5,
    LUI   = 4'd6,
    LBU   = 4'd7,
    LI    = 4'd8
  } enc_kind_t;

  typedef enum logic {S_IDLE, S_LI2} ld_state_t;

  typedef struct packed {
    enc_kind_t   kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [31:0] imm;
  } enc_req_t;

  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_SLLI = 3'b001;
  localparam logic [2:0] F3_SRXI = 3'b101;
  localparam logic [2:0] F3_JALR = 3'b000;
  localparam logic [2:0] F3_SB   = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_LBU  = 3'b100;

  // True when v is representable as an nbits-wide two's complement value.
  function automatic logic fits_simm(input logic [31:0] v, input int unsigned nbits);
    logic [31:0] hi;
    hi = 32'($signed(v) >>> (nbits - 1));
    return (hi == '0) || (hi == '1);
  endfunction

endpackage

// File: rtl/instr_format_enc.sv
// Combinational RV32I word builder: request kind + fields -> 32-bit instruction.
module instr_format_enc
  import enc_pkg::*;
(
  input  enc_req_t    req,
  output logic [31:0] word
);

  logic [31:0] imm;
  logic [6:0]  f7;
  logic        is_shift;

  always_comb begin
    imm      = req.imm;
    f7       = {1'b0, req.funct7b5, 5'b0};
    is_shift = (req.funct3 == F3_SLLI) || (req.funct3 == F3_SRXI);
    word     = '0;
    case (req.kind)
      JAL:   word = {imm[20], imm[10:1], imm[11], imm[19:12], req.rd, OPC_JAL};
      JALR:  word = {imm[11:0], req.rs1, F3_JALR, req.rd, OPC_JALR};
      OPIMM: begin
        // shifts carry the arith/logical select in bit 30 and shamt in [24:20]
        if (is_shift) word = {f7, imm[4:0], req.rs1, req.funct3, req.rd, OPC_OPIMM};
        else          word = {imm[11:0], req.rs1, req.funct3, req.rd, OPC_OPIMM};
      end
      OP:    word = {f7, req.rs2, req.rs1, req.funct3, req.rd, OPC_OP};
      SB:    word = {imm[11:5], req.rs2, req.rs1, F3_SB, imm[4:0], OPC_STORE};
      BNE:   word = {imm[12], imm[10:5], req.rs2, req.rs1, F3_BNE, imm[4:1], imm[11], OPC_BRANCH};
      LUI:   word = {imm[31:12], req.rd, OPC_LUI};
      LBU:   word = {imm[11:0], req.rs1, F3_LBU, req.rd, OPC_LOAD};
      LI:    word = {imm[11:0], req.rs1, F3_ADDI, req.rd, OPC_OPIMM};
      default: word = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes instruction requests and streams them into instruction memory.
// Optional immediate range checker: define ENC_RANGE_CHECK_EN.
module instr_encoder_loader
  import enc_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'hBFC00000),
  parameter int                    DEPTH      = 1024,
  localparam int                   CW         = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  enc_kind_t             kind_i,
  input  logic [4:0]            rd_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  input  logic [2:0]            funct3_i,
  input  logic                  funct7b5_i,
  input  logic [31:0]           imm_i,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [31:0]           wdata_o,
  output logic [CW-1:0]         count_o,
  output logic                  full_o,
  output logic                  overflow_o,
  output logic                  err_o
);

  ld_state_t             state, state_nxt;
  enc_req_t              req;
  logic [31:0]           word;
  logic                  xfer, emit, drop;
  logic [4:0]            li_rd;
  logic [11:0]           li_lo;
  logic [ADDR_WIDTH-1:0] next_addr;

  assign full_o  = (count_o == CW'(DEPTH));
  assign ready_o = (state == S_IDLE) && !full_o;
  assign xfer    = valid_i && ready_o;

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    drop      = 1'b0;
    req       = '{kind: kind_i, rd: rd_i, rs1: rs1_i, rs2: rs2_i,
                  funct3: funct3_i, funct7b5: funct7b5_i, imm: imm_i};
    case (state)
      S_IDLE: begin
        if (xfer) begin
          emit = 1'b1;
          if (kind_i == LI) begin
            if (fits_simm(imm_i, 12)) begin
              req.rs1 = 5'd0;
            end else begin
              // round the upper part so the signed low 12 bits land back on imm
              req.kind  = LUI;
              req.imm   = {imm_i[31:12] + {19'd0, imm_i[11]}, 12'd0};
              state_nxt = S_LI2;
            end
          end
        end
      end
      S_LI2: begin
        state_nxt = S_IDLE;
        emit      = !full_o;
        drop      = full_o;
        req.kind  = LI;
        req.rd    = li_rd;
        req.rs1   = li_rd;
        req.imm   = {{20{li_lo[11]}}, li_lo};
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  instr_format_enc u_fmt (
    .req  (req),
    .word (word)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      we_o       <= 1'b0;
      waddr_o    <= BASE_ADDR;
      next_addr  <= BASE_ADDR;
      wdata_o    <= '0;
      count_o    <= '0;
      overflow_o <= 1'b0;
      li_rd      <= '0;
      li_lo      <= '0;
    end else begin
      state <= state_nxt;
      we_o  <= emit;
      // idle cycles expose the address the next word will take
      if (emit) begin
        wdata_o   <= word;
        waddr_o   <= next_addr;
        next_addr <= next_addr + ADDR_WIDTH'(4);
        count_o   <= count_o + CW'(1);
      end else begin
        waddr_o <= next_addr;
      end
      if (drop) overflow_o <= 1'b1;
      if (xfer && (kind_i == LI)) begin
        li_rd <= rd_i;
        li_lo <= imm_i[11:0];
      end
    end
  end

`ifdef ENC_RANGE_CHECK_EN
  logic range_err;

  always_comb begin
    range_err = 1'b0;
    case (kind_i)
      JALR, OPIMM, SB, LBU: range_err = !fits_simm(imm_i, 12);
      BNE:                  range_err = !fits_simm(imm_i, 13) || imm_i[0];
      JAL:                  range_err = !fits_simm(imm_i, 21) || imm_i[0];
      default:              range_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) err_o <= 1'b0;
    else       err_o <= xfer && range_err;
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with a queue-based memory-write model.
module tb_instr_encoder_loader;
  import enc_pkg::*;

  localparam int          DEPTH = 2;
  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] BASE  = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  enc_kind_t   kind = OPIMM;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [2:0]  f3 = '0;
  logic        f7b5 = 1'b0;
  logic [31:0] imm = '0;
  logic        we, full, ovf, err;
  logic [31:0] waddr, wdata;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  instr_encoder_loader #(.ADDR_WIDTH(32), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_o(ready), .kind_i(kind),
    .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .funct3_i(f3), .funct7b5_i(f7b5), .imm_i(imm),
    .we_o(we), .waddr_o(waddr), .wdata_o(wdata), .count_o(count), .full_o(full),
    .overflow_o(ovf), .err_o(err)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  // ---------------- model ----------------
  logic [31:0] pend[$];
  logic        m_we = 1'b0, m_err = 1'b0, m_ovf = 1'b0;
  logic [31:0] m_addr = BASE, m_data = '0, m_next = BASE;
  int          m_cnt = 0;
  bit          live = 1'b0;

  function automatic logic [31:0] itype(input logic [31:0] i, input logic [4:0] s1,
                                        input logic [2:0] fn, input logic [4:0] d,
                                        input logic [6:0] opc);
    return ((i & 32'hFFF) << 20) | (32'(s1) << 15) | (32'(fn) << 12) | (32'(d) << 7) | 32'(opc);
  endfunction

  function automatic logic [31:0] m_enc(input enc_kind_t k, input logic [4:0] d,
                                        input logic [4:0] s1, input logic [4:0] s2,
                                        input logic [2:0] fn, input logic f7,
                                        input logic [31:0] i);
    logic [31:0] hi7, regs;
    hi7  = f7 ? 32'h4000_0000 : 32'h0;
    regs = (32'(s2) << 20) | (32'(s1) << 15);
    case (k)
      JAL:   return (32'(i[20]) << 31) | (((i >> 1) & 32'h3FF) << 21) | (32'(i[11]) << 20)
                  | (i & 32'hFF000) | (32'(d) << 7) | 32'h6F;
      JALR:  return itype(i, s1, 3'd0, d, 7'h67);
      OPIMM: if (fn == 3'd1 || fn == 3'd5)
               return hi7 | ((i & 32'h1F) << 20) | (32'(s1) << 15) | (32'(fn) << 12) | (32'(d) << 7) | 32'h13;
             else return itype(i, s1, fn, d, 7'h13);
      OP:    return hi7 | regs | (32'(fn) << 12) | (32'(d) << 7) | 32'h33;
      SB:    return (((i >> 5) & 32'h7F) << 25) | regs | ((i & 32'h1F) << 7) | 32'h23;
      BNE:   return (32'(i[12]) << 31) | (((i >> 5) & 32'h3F) << 25) | regs | (32'd1 << 12)
                  | (((i >> 1) & 32'hF) << 8) | (32'(i[11]) << 7) | 32'h63;
      LUI:   return (i & 32'hFFFFF000) | (32'(d) << 7) | 32'h37;
      LBU:   return itype(i, s1, 3'd4, d, 7'h03);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_rerr(input enc_kind_t k, input logic [31:0] i);
`ifdef ENC_RANGE_CHECK_EN
    int s;
    s = int'(i);
    case (k)
      JALR, OPIMM, SB, LBU: return (s < -2048) || (s > 2047);
      BNE: return (s < -4096) || (s > 4094) || i[0];
      JAL: return (s < -1048576) || (s > 1048574) || i[0];
      default: return 1'b0;
    endcase
`else
    return (k == LI) && (i == 32'hFFFF_FFFF) && 1'b0;
`endif
  endfunction

  function automatic bit m_ready();
    return (pend.size() == 0) && (m_cnt < DEPTH);
  endfunction

  initial forever begin
    @(posedge clk);
    if (rst) begin
      pend.delete();
      m_we = 0; m_err = 0; m_ovf = 0; m_cnt = 0; m_next = BASE; m_addr = BASE;
      live = 1'b1;
    end else if (live) begin
      logic [31:0] w;
      bit have, e, rdy;
      int s;
      longint hi;
      have = 0; e = 0; w = '0;
      rdy = m_ready();
      if (pend.size() != 0) begin
        w = pend.pop_front();
        have = 1;
      end else if (valid && rdy) begin
        have = 1;
        if (kind == LI) begin
          s = int'(imm);
          if (s >= -2048 && s <= 2047) w = itype(imm, 5'd0, 3'd0, rd, 7'h13);
          else begin
            hi = (longint'(s) + 2048) >>> 12;
            w  = ((32'(hi) & 32'hFFFFF) << 12) | (32'(rd) << 7) | 32'h37;
            pend.push_back(itype(imm, rd, 3'd0, rd, 7'h13));
          end
        end else begin
          w = m_enc(kind, rd, rs1, rs2, f3, f7b5, imm);
          e = m_rerr(kind, imm);
        end
      end
      m_we = 0; m_err = 0;
      if (have) begin
        if (m_cnt < DEPTH) begin
          m_we = 1; m_err = e; m_data = w; m_addr = m_next;
          m_next = m_next + 32'd4; m_cnt++;
        end else m_ovf = 1;
      end
    end
  end

  // per-cycle compare against the model
  initial forever begin
    @(negedge clk);
    if (live && !rst) begin
      chk("we", 32'(we), 32'(m_we));
      if (m_we) begin
        chk("waddr", waddr, m_addr);
        chk("wdata", wdata, m_data);
      end
      chk("err", 32'(err), 32'(m_err));
      chk("count", 32'(count), 32'(m_cnt));
      chk("full", 32'(full), 32'(m_cnt == DEPTH));
      chk("overflow", 32'(ovf), 32'(m_ovf));
      chk("ready", 32'(ready), 32'(m_ready()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input enc_kind_t k, input logic [4:0] d, input logic [4:0] s1,
                      input logic [4:0] s2, input logic [2:0] fn, input logic f7,
                      input logic [31:0] i);
    int t;
    @(negedge clk);
    kind = k; rd = d; rs1 = s1; rs2 = s2; f3 = fn; f7b5 = f7; imm = i; valid = 1'b1;
    t = 0;
    while (!m_ready() && t < 8) begin
      @(negedge clk);
      t++;
    end
    if (t == 8) begin
      n_chk++;
      $display("FAIL handshake_timeout: got no accept want accept within 8 cycles");
      valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want summary");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_waddr", waddr, BASE);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);

    send(OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
    @(negedge clk);
    chk("addi_we", 32'(we), 32'd1);
    chk("addi_addr", waddr, 32'hBFC00000);
    chk("addi_data", wdata, 32'h00500093);
    chk("addi_count", 32'(count), 32'd1);

    do_reset();
    send(LI, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345FFF);
    @(negedge clk);
    chk("li_lui_data", wdata, 32'h123462B7);
    chk("li_lui_addr", waddr, 32'hBFC00000);
    chk("li2_ready", 32'(ready), 32'd0);
    @(negedge clk);
    chk("li_addi_we", 32'(we), 32'd1);
    chk("li_addi_data", wdata, 32'hFFF28293);
    chk("li_addi_addr", waddr, 32'hBFC00004);

    do_reset();
    send(BNE, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, -32'sd4);
    @(negedge clk);
    chk("bne_data", wdata, 32'hFE209EE3);
    send(JAL, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8);
    @(negedge clk);
    chk("jal_data", wdata, 32'h008000EF);

    do_reset();
    send(OP, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0);
    @(negedge clk);
    chk("sub_data", wdata, 32'h402081B3);
    send(SB, 5'd0, 5'd2, 5'd5, 3'd0, 1'b0, -32'sd8);
    @(negedge clk);
    chk("sb_data", wdata, 32'hFE510C23);

    do_reset();
    send(LBU, 5'd6, 5'd7, 5'd0, 3'd0, 1'b0, 32'd3);
    @(negedge clk);
    chk("lbu_data", wdata, 32'h0033C303);
    send(LUI, 5'd10, 5'd0, 5'd0, 3'd0, 1'b0, 32'hDEADB000);
    @(negedge clk);
    chk("lui_data", wdata, 32'hDEADB537);

    do_reset();
    send(JALR, 5'd0, 5'd1, 5'd0, 3'd0, 1'b0, 32'd0);
    @(negedge clk);
    chk("jalr_data", wdata, 32'h00008067);
    send(OPIMM, 5'd4, 5'd4, 5'd0, 3'd5, 1'b1, 32'd3);
    @(negedge clk);
    chk("srai_data", wdata, 32'h40325213);

    do_reset();
    send(LI, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 32'hFFFFFFFF);
    @(negedge clk);
    chk("li_small_data", wdata, 32'hFFF00113);
    chk("li_small_ready", 32'(ready), 32'd1);

    do_reset();
    send(LI, 5'd3, 5'd0, 5'd0, 3'd0, 1'b0, 32'd2048);
    @(negedge clk);
    chk("li2048_lui", wdata, 32'h000011B7);
    @(negedge clk);
    chk("li2048_addi", wdata, 32'h80018193);

    // fill to capacity with the lui, forcing the addi to be dropped
    do_reset();
    send(OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
    send(LI, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345FFF);
    @(negedge clk);
    chk("ovf_lui_data", wdata, 32'h123462B7);
    chk("ovf_full", 32'(full), 32'd1);
    @(negedge clk);
    chk("ovf_drop_we", 32'(we), 32'd0);
    chk("ovf_flag", 32'(ovf), 32'd1);
    chk("ovf_ready", 32'(ready), 32'd0);
    chk("ovf_waddr", waddr, 32'hBFC00008);
    repeat (2) @(negedge clk);
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // reset landing in the LI2 cycle discards the pending addi
    do_reset();
    send(LI, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345FFF);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_li2_we", 32'(we), 32'd0);
    chk("rst_li2_waddr", waddr, BASE);
    chk("rst_li2_count", 32'(count), 32'd0);
    send(OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5);
    @(negedge clk);
    chk("rst_li2_next_addr", waddr, BASE);
    chk("rst_li2_next_data", wdata, 32'h00500093);

    do_reset();
    send(OPIMM, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd4096);
    @(negedge clk);
    chk("rng_opimm_data", wdata, 32'h00000093);
`ifdef ENC_RANGE_CHECK_EN
    chk("rng_opimm_err", 32'(err), 32'd1);
`else
    chk("rng_opimm_err", 32'(err), 32'd0);
`endif
    send(BNE, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'd3);
    @(negedge clk);
    chk("rng_bne_data", wdata, 32'h00209163);
`ifdef ENC_RANGE_CHECK_EN
    chk("rng_bne_err", 32'(err), 32'd1);
`else
    chk("rng_bne_err", 32'(err), 32'd0);
`endif
    @(negedge clk);
    chk("rng_err_pulse", 32'(err), 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
